prism_sp_puzzle_hw_gem_irq_coalesce: RTL and testbench

- Producer end of the GEM interrupt-event FIFO. Collects per-source event pulses from the GEM datapath (rx done, tx done, rx error, tx error).
- Coalesces them by count threshold or timeout.
- Writes one event record per coalesced burst into the FIFO write port. The FIFO consumer turns each record into one ISR pulse.

---
 rtl/prism_sp_gem_irq_pkg.sv | 19 +
 rtl/prism_sp_puzzle_hw_gem_irq_coalesce.sv | 132 +++++++++++++
 tb/tb_prism_sp_puzzle_hw_gem_irq_coalesce.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prism_sp_gem_irq_pkg.sv
// Shared definitions for the GEM interrupt-event coalescer: source indices,
// event-record field offsets and the coalescer state type.
package prism_sp_gem_irq_pkg;

   localparam int unsigned GEM_IRQ_SRC_RX_DONE = 0;
   localparam int unsigned GEM_IRQ_SRC_TX_DONE = 1;
   localparam int unsigned GEM_IRQ_SRC_RX_ERR  = 2;
   localparam int unsigned GEM_IRQ_SRC_TX_ERR  = 3;

   localparam int unsigned MASK_LSB  = 0;
   localparam int unsigned COUNT_LSB = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      STALL = 2'd2
   } gem_irq_state_t;

endpackage

// File: rtl/prism_sp_puzzle_hw_gem_irq_coalesce.sv
// Producer side of the GEM interrupt-event FIFO: merges per-source event pulses
// and writes one record per burst, flushed on count threshold or timeout.
module prism_sp_puzzle_hw_gem_irq_coalesce
   import prism_sp_gem_irq_pkg::*;
#(
   parameter int unsigned NUM_SRC     = 4,
   parameter int unsigned CNT_WIDTH   = 8,
   parameter int unsigned TIMER_WIDTH = 16,
   parameter int unsigned DATA_WIDTH  = 32
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic [NUM_SRC-1:0]     event_pulse,
   input  logic                   cfg_enable,
   input  logic [CNT_WIDTH-1:0]   cfg_threshold,
   input  logic [TIMER_WIDTH-1:0] cfg_timeout,
   output logic                   fifo_wr_en,
   output logic [DATA_WIDTH-1:0]  fifo_din,
   input  logic                   fifo_full,
   output logic                   overflow,
   input  logic                   clear_overflow,
   output logic [CNT_WIDTH-1:0]   pending_count
);

   localparam int unsigned TMR_EXT = TIMER_WIDTH + 1;

   gem_irq_state_t         state;
   logic [NUM_SRC-1:0]     mask;
   logic [CNT_WIDTH-1:0]   count;
   logic [TIMER_WIDTH-1:0] timer;

   logic [NUM_SRC-1:0]     pulses;
   logic [NUM_SRC-1:0]     merged;
   logic                   hit;
   logic [CNT_WIDTH-1:0]   cnt_n;
   logic [CNT_WIDTH-1:0]   thr_eff;
   logic [TMR_EXT-1:0]     timer_p1;
   logic [TIMER_WIDTH-1:0] timer_inc;
   logic                   tmo;
   logic                   flush;
   logic [DATA_WIDTH-1:0]  record;

   // Per-cycle flush evaluation; the current cycle's pulses always join the record.
   always_comb begin
      pulses    = cfg_enable ? event_pulse : '0;
      hit       = |pulses;
      merged    = mask | pulses;
      cnt_n     = (hit && (count != '1)) ? count + CNT_WIDTH'(1) : count;
      thr_eff   = (cfg_threshold == '0) ? CNT_WIDTH'(1) : cfg_threshold;
      timer_p1  = {1'b0, timer} + TMR_EXT'(1);
      timer_inc = (timer == '1) ? timer : timer + TIMER_WIDTH'(1);
      tmo       = (cfg_timeout != '0) && (timer_p1 >= {1'b0, cfg_timeout}) && (cnt_n != '0);
      flush     = (cnt_n >= thr_eff) || tmo;
      record    = '0;
      record[MASK_LSB +: NUM_SRC]    = merged;
      record[COUNT_LSB +: CNT_WIDTH] = cnt_n;
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state      <= IDLE;
         mask       <= '0;
         count      <= '0;
         timer      <= '0;
         fifo_wr_en <= 1'b0;
         fifo_din   <= '0;
         overflow   <= 1'b0;
      end else begin
         fifo_wr_en <= 1'b0;

         // A saturating hit outranks a simultaneous clear.
         if (hit && (count == '1)) begin
            overflow <= 1'b1;
         end else if (clear_overflow) begin
            overflow <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (hit) begin
                  if (flush && !fifo_full) begin
                     fifo_wr_en <= 1'b1;
                     fifo_din   <= record;
                  end else begin
                     mask  <= merged;
                     count <= cnt_n;
                     timer <= flush ? '0 : TIMER_WIDTH'(1);
                     state <= flush ? STALL : ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (!cfg_enable) begin
                  mask  <= '0;
                  count <= '0;
                  timer <= '0;
                  state <= IDLE;
               end else if (flush && !fifo_full) begin
                  fifo_wr_en <= 1'b1;
                  fifo_din   <= record;
                  mask       <= '0;
                  count      <= '0;
                  timer      <= '0;
                  state      <= IDLE;
               end else begin
                  mask  <= merged;
                  count <= cnt_n;
                  timer <= timer_inc;
                  if (flush) state <= STALL;
               end
            end
            STALL: begin
               if (!fifo_full) begin
                  fifo_wr_en <= 1'b1;
                  fifo_din   <= record;
                  mask       <= '0;
                  count      <= '0;
                  timer      <= '0;
                  state      <= IDLE;
               end else begin
                  mask  <= merged;
                  count <= cnt_n;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign pending_count = count;

endmodule

// File: tb/tb_prism_sp_puzzle_hw_gem_irq_coalesce.sv
// Bench for the GEM interrupt coalescer: directed scenarios plus a randomized
// run compared every cycle against a pending-burst reference model.
module tb_prism_sp_puzzle_hw_gem_irq_coalesce;

   localparam int unsigned NS   = 4;
   localparam int unsigned CW   = 8;
   localparam int unsigned TW   = 16;
   localparam int          CMAX = 255;
   localparam int          TMAX = 65535;

   logic          clock = 1'b0;
   logic          resetn;
   logic [NS-1:0] event_pulse;
   logic          cfg_enable;
   logic [CW-1:0] cfg_threshold;
   logic [TW-1:0] cfg_timeout;
   logic          fifo_wr_en;
   logic [31:0]   fifo_din;
   logic          fifo_full;
   logic          overflow;
   logic          clear_overflow;
   logic [CW-1:0] pending_count;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a pending burst described by its hit count, merged
   // sources, age in cycles and whether it is waiting on a full FIFO.
   int          m_cnt, m_mask, m_age;
   bit          m_wait, m_wr, m_ov;
   logic [31:0] m_din;

   prism_sp_puzzle_hw_gem_irq_coalesce #(
      .NUM_SRC(NS), .CNT_WIDTH(CW), .TIMER_WIDTH(TW), .DATA_WIDTH(32)
   ) dut (
      .clock(clock), .resetn(resetn), .event_pulse(event_pulse),
      .cfg_enable(cfg_enable), .cfg_threshold(cfg_threshold),
      .cfg_timeout(cfg_timeout), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
      .fifo_full(fifo_full), .overflow(overflow),
      .clear_overflow(clear_overflow), .pending_count(pending_count)
   );

   always #5 clock = ~clock;

   task automatic model_clear();
      m_cnt  = 0;
      m_mask = 0;
      m_age  = 0;
      m_wait = 1'b0;
   endtask

   // Advance one clock edge, updating the model from the inputs seen at the edge.
   task automatic tick();
      int p, nc, nm, thr;
      bit h, due;
      @(posedge clock);
      if (!resetn) begin
         model_clear();
         m_wr  = 1'b0;
         m_din = '0;
         m_ov  = 1'b0;
      end else begin
         p   = cfg_enable ? int'(event_pulse) : 0;
         h   = (p != 0);
         m_wr = 1'b0;
         if (h && m_cnt == CMAX) m_ov = 1'b1;
         else if (clear_overflow) m_ov = 1'b0;
         nc  = (m_cnt + int'(h) > CMAX) ? CMAX : m_cnt + int'(h);
         nm  = m_mask | p;
         thr = (cfg_threshold == 0) ? 1 : int'(cfg_threshold);
         if (m_wait) begin
            if (!fifo_full) begin
               m_wr = 1'b1; m_din = (32'(nc) << 16) | 32'(nm); model_clear();
            end else begin
               m_cnt = nc; m_mask = nm;
            end
         end else if (!cfg_enable) begin
            model_clear();
         end else if (m_cnt != 0 || h) begin
            due = (nc >= thr) ||
                  (cfg_timeout != 0 && m_age + 1 >= int'(cfg_timeout) && nc != 0);
            if (due && !fifo_full) begin
               m_wr = 1'b1; m_din = (32'(nc) << 16) | 32'(nm); model_clear();
            end else begin
               m_cnt = nc; m_mask = nm;
               if (due) m_wait = 1'b1;
               else m_age = (m_age + 1 > TMAX) ? TMAX : m_age + 1;
            end
         end
      end
      #1;
   endtask

   task automatic set_defaults();
      event_pulse    = '0;
      cfg_enable     = 1'b1;
      cfg_threshold  = CW'(1);
      cfg_timeout    = '0;
      fifo_full      = 1'b0;
      clear_overflow = 1'b0;
      resetn         = 1'b1;
   endtask

   task automatic test_reset();
      set_defaults();
      resetn = 1'b0;
      tick(); tick();
      n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr got %0b want 0", fifo_wr_en); end
      n_tests++; if (fifo_din !== 32'h0) begin n_fail++; $display("FAIL reset_din got %h want 0", fifo_din); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0b want 0", overflow); end
      n_tests++; if (pending_count !== 8'h0) begin n_fail++; $display("FAIL reset_pend got %0d want 0", pending_count); end
      resetn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      set_defaults();
      event_pulse = 4'b0001;
      tick();
      event_pulse = '0;
      n_tests++; if (fifo_wr_en !== 1'b1) begin n_fail++; $display("FAIL single_wr got %0b want 1", fifo_wr_en); end
      n_tests++; if (fifo_din !== 32'h0001_0001) begin n_fail++; $display("FAIL single_din got %h want 00010001", fifo_din); end
      tick();
      n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL single_wr_drop got %0b want 0", fifo_wr_en); end
   endtask

   task automatic test_threshold();
      logic [NS-1:0] pat [5];
      int            pend [5];
      pat  = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100};
      pend = '{1, 1, 2, 2, 0};
      set_defaults();
      cfg_threshold = CW'(3);
      for (int i = 0; i < 5; i++) begin
         event_pulse = pat[i];
         tick();
         n_tests++; if (fifo_wr_en !== (i == 4)) begin n_fail++; $display("FAIL thr_wr step %0d got %0b want %0b", i, fifo_wr_en, i == 4); end
         n_tests++; if (int'(pending_count) != pend[i]) begin n_fail++; $display("FAIL thr_pend step %0d got %0d want %0d", i, pending_count, pend[i]); end
      end
      event_pulse = '0;
      n_tests++; if (fifo_din !== 32'h0003_0007) begin n_fail++; $display("FAIL thr_din got %h want 00030007", fifo_din); end
      tick();
   endtask

   task automatic test_timeout();
      set_defaults();
      cfg_threshold = CW'(8);
      cfg_timeout   = TW'(5);
      event_pulse   = 4'b1000;
      for (int i = 1; i <= 7; i++) begin
         tick();
         event_pulse = '0;
         n_tests++; if (fifo_wr_en !== (i == 5)) begin n_fail++; $display("FAIL tmo_wr tick %0d got %0b want %0b", i, fifo_wr_en, i == 5); end
         if (i == 5) begin
            n_tests++; if (fifo_din !== 32'h0001_0008) begin n_fail++; $display("FAIL tmo_din got %h want 00010008", fifo_din); end
         end
      end
   endtask

   task automatic test_stall();
      set_defaults();
      fifo_full = 1'b1;
      for (int c = 10; c <= 20; c++) begin
         event_pulse = (c == 10) ? 4'b0001 : (c == 13) ? 4'b0010 : (c == 20) ? 4'b0100 : 4'b0000;
         if (c == 20) fifo_full = 1'b0;
         tick();
         n_tests++; if (fifo_wr_en !== (c == 20)) begin n_fail++; $display("FAIL stall_wr cycle %0d got %0b want %0b", c, fifo_wr_en, c == 20); end
         if (c == 19) begin
            n_tests++; if (pending_count !== 8'd2) begin n_fail++; $display("FAIL stall_pend got %0d want 2", pending_count); end
         end
      end
      event_pulse = '0;
      n_tests++; if (fifo_din !== 32'h0003_0007) begin n_fail++; $display("FAIL stall_din got %h want 00030007", fifo_din); end
      tick();
   endtask

   task automatic test_saturate();
      set_defaults();
      cfg_threshold = '0;
      fifo_full     = 1'b1;
      event_pulse   = 4'b0001;
      for (int i = 0; i < 300; i++) tick();
      n_tests++; if (pending_count !== 8'hFF) begin n_fail++; $display("FAIL sat_pend got %h want ff", pending_count); end
      n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got %0b want 1", overflow); end
      event_pulse = '0; clear_overflow = 1'b1;
      tick();
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL sat_clear got %0b want 0", overflow); end
      event_pulse = 4'b0001; clear_overflow = 1'b0;
      tick();
      clear_overflow = 1'b1;
      tick();
      n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL sat_set_wins got %0b want 1", overflow); end
      event_pulse = '0; clear_overflow = 1'b0; fifo_full = 1'b0;
      tick();
      n_tests++; if (fifo_wr_en !== 1'b1 || fifo_din !== 32'h00FF_0001) begin n_fail++; $display("FAIL sat_flush got wr=%0b din=%h want wr=1 din=00ff0001", fifo_wr_en, fifo_din); end
      clear_overflow = 1'b1;
      tick();
   endtask

   task automatic test_disable_reset();
      set_defaults();
      cfg_threshold = CW'(4);
      event_pulse = 4'b0001; tick();
      event_pulse = 4'b0010; tick();
      n_tests++; if (pending_count !== 8'd2) begin n_fail++; $display("FAIL dis_pend_pre got %0d want 2", pending_count); end
      event_pulse = '0; cfg_enable = 1'b0;
      tick();
      n_tests++; if (pending_count !== 8'd0 || fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL dis_discard got pend=%0d wr=%0b want 0 0", pending_count, fifo_wr_en); end
      cfg_enable = 1'b1; cfg_threshold = CW'(1); fifo_full = 1'b1; event_pulse = 4'b0100;
      tick();
      event_pulse = '0; resetn = 1'b0;
      tick();
      n_tests++; if (fifo_wr_en !== 1'b0 || fifo_din !== 32'h0 || pending_count !== 8'd0 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL rst_stall got wr=%0b din=%h pend=%0d ovf=%0b want all 0", fifo_wr_en, fifo_din, pending_count, overflow);
      end
      resetn = 1'b1; fifo_full = 1'b0;
      tick();
      n_tests++; if (fifo_wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_no_write got %0b want 0", fifo_wr_en); end
   endtask

   task automatic test_random();
      set_defaults();
      for (int c = 0; c < 3000; c++) begin
         event_pulse    = ($urandom_range(0, 9) < 3) ? NS'($urandom) : '0;
         fifo_full      = ($urandom_range(0, 9) < 3);
         clear_overflow = ($urandom_range(0, 19) == 0);
         cfg_enable     = ($urandom_range(0, 39) != 0);
         resetn         = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 49) == 0) begin
            cfg_threshold = CW'($urandom_range(0, 6));
            cfg_timeout   = TW'($urandom_range(0, 8));
         end
         tick();
         n_tests++; if (fifo_wr_en !== m_wr) begin n_fail++; $display("FAIL rnd_wr cycle %0d got %0b want %0b", c, fifo_wr_en, m_wr); end
         n_tests++; if (fifo_din !== m_din) begin n_fail++; $display("FAIL rnd_din cycle %0d got %h want %h", c, fifo_din, m_din); end
         n_tests++; if (int'(pending_count) != m_cnt) begin n_fail++; $display("FAIL rnd_pend cycle %0d got %0d want %0d", c, pending_count, m_cnt); end
         n_tests++; if (overflow !== m_ov) begin n_fail++; $display("FAIL rnd_ovf cycle %0d got %0b want %0b", c, overflow, m_ov); end
      end
   endtask

   initial begin
      set_defaults();
      test_reset();
      test_single();
      test_threshold();
      test_timeout();
      test_stall();
      test_saturate();
      test_disable_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
